// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data-memory port arbiter between pipeline M-stage and secondary requester
module dmem_arbiter #(
  parameter int D_WIDTH  = 32,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m_req,
  input  logic               m_we,
  input  logic               m_adtp,
  input  logic [D_WIDTH-1:0] m_addr,
  input  logic [D_WIDTH-1:0] m_wdata,
  output logic [D_WIDTH-1:0] m_rdata,
  output logic               m_done,
  output logic               stall_o,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_we,
  input  logic               s_adtp,
  input  logic [D_WIDTH-1:0] s_addr,
  input  logic [D_WIDTH-1:0] s_wdata,
  output logic               s_rvalid,
  output logic [D_WIDTH-1:0] s_rdata,
  output logic               mem_we,
  output logic               mem_adtp,
  output logic [D_WIDTH-1:0] mem_a,
  output logic [D_WIDTH-1:0] mem_wd,
  input  logic [D_WIDTH-1:0] mem_rd
);

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [LW-1:0] LAT_INIT = LW'(MEM_LAT - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, RD_M, RD_S} state_t;

  state_t             state_q, state_d;
  logic [LW-1:0]      lat_q, lat_d;
  logic [WW-1:0]      wait_q, wait_d;
  logic [D_WIDTH-1:0] s_addr_q, s_addr_d;
  logic               s_adtp_q, s_adtp_d;
  logic [D_WIDTH-1:0] m_rdata_q, m_rdata_d;
  logic [D_WIDTH-1:0] s_rdata_q, s_rdata_d;
  logic               starve;
  logic [WW-1:0]      wait_inc;

  // Secondary wins once it has been denied MAX_WAIT consecutive times
  always_comb begin
    starve   = (wait_q == WAIT_MAX);
    wait_inc = starve ? wait_q : wait_q + WW'(1);
  end

  // State, latency/wait counters, latched secondary read address and captured read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      wait_q    <= '0;
      s_addr_q  <= '0;
      s_adtp_q  <= 1'b0;
      m_rdata_q <= '0;
      s_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      wait_q    <= wait_d;
      s_addr_q  <= s_addr_d;
      s_adtp_q  <= s_adtp_d;
      m_rdata_q <= m_rdata_d;
      s_rdata_q <= s_rdata_d;
    end
  end

  // Arbitration, read sequencing and memory-port muxing; everything forced quiet while rst is high
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    wait_d    = wait_q;
    s_addr_d  = s_addr_q;
    s_adtp_d  = s_adtp_q;
    m_rdata_d = m_rdata_q;
    s_rdata_d = s_rdata_q;
    m_done    = 1'b0;
    s_ready   = 1'b0;
    s_rvalid  = 1'b0;
    mem_we    = 1'b0;
    mem_adtp  = 1'b0;
    mem_a     = '0;
    mem_wd    = '0;
    m_rdata   = rst ? '0 : m_rdata_q;
    s_rdata   = rst ? '0 : s_rdata_q;

    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (s_valid && (starve || !m_req)) begin
            s_ready  = 1'b1;
            wait_d   = '0;
            mem_a    = s_addr;
            mem_wd   = s_wdata;
            mem_adtp = s_adtp;
            mem_we   = s_we;
            if (!s_we) begin
              state_d  = RD_S;
              lat_d    = LAT_INIT;
              s_addr_d = s_addr;
              s_adtp_d = s_adtp;
            end
          end else if (m_req) begin
            mem_a    = m_addr;
            mem_wd   = m_wdata;
            mem_adtp = m_adtp;
            mem_we   = m_we;
            if (s_valid) begin
              wait_d = wait_inc;
            end
            if (m_we) begin
              m_done = 1'b1;
            end else begin
              state_d = RD_M;
              lat_d   = LAT_INIT;
            end
          end
        end
        RD_M: begin
          mem_a    = m_addr;
          mem_adtp = m_adtp;
          if (s_valid) begin
            wait_d = wait_inc;
          end
          if (lat_q == '0) begin
            m_done    = 1'b1;
            m_rdata   = mem_rd;
            m_rdata_d = mem_rd;
            state_d   = IDLE;
          end else begin
            lat_d = lat_q - LW'(1);
          end
        end
        RD_S: begin
          mem_a    = s_addr_q;
          mem_adtp = s_adtp_q;
          if (lat_q == '0) begin
            s_rvalid  = 1'b1;
            s_rdata   = mem_rd;
            s_rdata_d = mem_rd;
            state_d   = IDLE;
          end else begin
            lat_d = lat_q - LW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Pipeline freezes whenever it has an access that is not completing this cycle
  always_comb begin
    stall_o = m_req && !m_done && !rst;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_req, m_we, m_adtp;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_done, stall_o;
  logic        s_valid, s_ready, s_we, s_adtp;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        s_rvalid;
  logic        mem_we, mem_adtp;
  logic [31:0] mem_a, mem_wd, mem_rd;

  int checks = 0;
  int failures = 0;

  dmem_arbiter #(.D_WIDTH(32), .MEM_LAT(2), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_adtp(m_adtp), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_done(m_done), .stall_o(stall_o),
    .s_valid(s_valid), .s_ready(s_ready), .s_we(s_we), .s_adtp(s_adtp),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .mem_we(mem_we), .mem_adtp(mem_adtp), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_m(input logic req, input logic we, input logic adtp,
                       input logic [31:0] addr, input logic [31:0] wd);
    m_req = req; m_we = we; m_adtp = adtp; m_addr = addr; m_wdata = wd;
  endtask

  task automatic set_s(input logic v, input logic we, input logic adtp,
                       input logic [31:0] addr, input logic [31:0] wd);
    s_valid = v; s_we = we; s_adtp = adtp; s_addr = addr; s_wdata = wd;
  endtask

  initial begin
    rst = 1'b1;
    mem_rd = 32'h0;
    set_m(1'b1, 1'b1, 1'b1, 32'h10, 32'h1111_2222);
    set_s(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(); #1;
    chk("rst_stall", stall_o, 0);
    chk("rst_mdone", m_done, 0);
    chk("rst_memwe", mem_we, 0);
    chk("rst_mema", mem_a, 0);
    chk("rst_mrdata", m_rdata, 0);
    chk("rst_sready", s_ready, 0);

    // pipeline store completes in the grant cycle
    cyc();
    rst = 1'b0;
    set_m(1'b1, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    #1;
    chk("st_memwe", mem_we, 1);
    chk("st_mema", mem_a, 32'h10);
    chk("st_memwd", mem_wd, 32'hDEAD_BEEF);
    chk("st_adtp", mem_adtp, 1);
    chk("st_mdone", m_done, 1);
    chk("st_stall", stall_o, 0);

    // pipeline load, MEM_LAT=2
    cyc();
    set_m(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    #1;
    chk("ld_issue_stall", stall_o, 1);
    chk("ld_issue_done", m_done, 0);
    chk("ld_issue_mema", mem_a, 32'h20);
    chk("ld_issue_we", mem_we, 0);
    cyc(); #1;
    chk("ld_wait_stall", stall_o, 1);
    chk("ld_wait_done", m_done, 0);
    chk("ld_wait_mema", mem_a, 32'h20);
    cyc();
    mem_rd = 32'h1234_5678;
    #1;
    chk("ld_done", m_done, 1);
    chk("ld_rdata", m_rdata, 32'h1234_5678);
    chk("ld_stall", stall_o, 0);
    cyc();
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    mem_rd = 32'h0;
    #1;
    chk("ld_hold_rdata", m_rdata, 32'h1234_5678);
    chk("ld_idle_done", m_done, 0);
    chk("ld_idle_mema", mem_a, 0);

    // simultaneous pipeline load and secondary store: pipeline wins
    cyc();
    set_m(1'b1, 1'b0, 1'b0, 32'h30, 32'h0);
    set_s(1'b1, 1'b1, 1'b0, 32'h80, 32'hCAFE_0001);
    #1;
    chk("sim_sready0", s_ready, 0);
    chk("sim_mema", mem_a, 32'h30);
    cyc(); #1;
    chk("sim_sready1", s_ready, 0);
    cyc();
    mem_rd = 32'hAAAA_0030;
    #1;
    chk("sim_mdone", m_done, 1);
    chk("sim_sready2", s_ready, 0);
    chk("sim_rdata", m_rdata, 32'hAAAA_0030);
    cyc();
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("sim_s_grant", s_ready, 1);
    chk("sim_s_memwe", mem_we, 1);
    chk("sim_s_mema", mem_a, 32'h80);
    chk("sim_s_memwd", mem_wd, 32'hCAFE_0001);

    // starvation: back-to-back pipeline stores, secondary held
    cyc();
    set_s(1'b1, 1'b1, 1'b0, 32'h90, 32'h5555_0090);
    for (int i = 0; i < 4; i++) begin
      set_m(1'b1, 1'b1, 1'b0, 32'h100 + 32'(i * 4), 32'h0);
      #1;
      chk($sformatf("starve_deny%0d_sready", i), s_ready, 0);
      chk($sformatf("starve_deny%0d_mdone", i), m_done, 1);
      cyc();
    end
    set_m(1'b1, 1'b1, 1'b0, 32'h110, 32'h0);
    #1;
    chk("starve_grant_sready", s_ready, 1);
    chk("starve_grant_mdone", m_done, 0);
    chk("starve_grant_stall", stall_o, 1);
    chk("starve_grant_mema", mem_a, 32'h90);
    cyc();
    set_s(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("starve_after_mdone", m_done, 1);

    // secondary load, address held while pipeline waits behind it
    cyc();
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_s(1'b1, 1'b0, 1'b1, 32'h40, 32'h0);
    #1;
    chk("sld_sready", s_ready, 1);
    chk("sld_mema", mem_a, 32'h40);
    chk("sld_stall", stall_o, 0);
    cyc();
    set_s(1'b0, 1'b0, 1'b0, 32'hFFFF_0000, 32'h0);
    set_m(1'b1, 1'b0, 1'b0, 32'h50, 32'h0);
    #1;
    chk("sld_wait_rvalid", s_rvalid, 0);
    chk("sld_wait_mema", mem_a, 32'h40);
    chk("sld_wait_adtp", mem_adtp, 1);
    chk("sld_wait_stall", stall_o, 1);
    chk("sld_wait_sready", s_ready, 0);
    cyc();
    mem_rd = 32'hA5A5_0040;
    #1;
    chk("sld_rvalid", s_rvalid, 1);
    chk("sld_rdata", s_rdata, 32'hA5A5_0040);
    chk("sld_stall_mreq", stall_o, 1);
    chk("sld_mdone", m_done, 0);
    cyc();
    mem_rd = 32'h0;
    #1;
    chk("sld_rvalid_end", s_rvalid, 0);
    chk("sld_rdata_hold", s_rdata, 32'hA5A5_0040);
    chk("m_after_s_mema", mem_a, 32'h50);
    chk("m_after_s_stall", stall_o, 1);

    // reset during outstanding pipeline load
    cyc();
    mem_rd = 32'hBAD0_BAD0;
    rst = 1'b1;
    #1;
    chk("rstm_stall", stall_o, 0);
    chk("rstm_mdone", m_done, 0);
    chk("rstm_mema", mem_a, 0);
    chk("rstm_rdata", m_rdata, 0);
    cyc();
    rst = 1'b0;
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("rstm_nodone%0d", i), m_done, 0);
      chk($sformatf("rstm_norvalid%0d", i), s_rvalid, 0);
      cyc();
    end
    set_m(1'b1, 1'b1, 1'b0, 32'h60, 32'h7);
    #1;
    chk("rstm_idle_store", m_done, 1);
    chk("rstm_idle_mema", mem_a, 32'h60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
